// File: rtl/fifo_rd_packer_if.sv
// Read-side packer bus: FIFO read port plus the packed valid/ready output stream.
interface fifo_rd_packer_if #(
    parameter int DATA_WIDTH = 8,
    parameter int PACK       = 4
);
    logic                       empty;
    logic [DATA_WIDTH-1:0]      dout;
    logic                       r_en;
    logic                       flush;
    logic [DATA_WIDTH*PACK-1:0] m_data;
    logic [PACK-1:0]            m_keep;
    logic                       m_valid;
    logic                       m_ready;

    // Packer side: consumes the FIFO read port, drives the output stream.
    modport slave (
        input  empty, dout, flush, m_ready,
        output r_en, m_data, m_keep, m_valid
    );

    // Environment side: FIFO and downstream sink.
    modport master (
        output empty, dout, flush, m_ready,
        input  r_en, m_data, m_keep, m_valid
    );
endinterface

// File: rtl/fifo_rd_packer.sv
// Pops bytes from the async FIFO read port, packs PACK of them little-endian
// into one word and presents it on a valid/ready stream with a lane keep mask.
// Partial words are flushed on request or after TIMEOUT idle cycles.
module fifo_rd_packer #(
    parameter int DATA_WIDTH = 8,
    parameter int PACK       = 4,
    parameter int TIMEOUT    = 16
) (
    input logic             rclk,
    input logic             rrst,
    fifo_rd_packer_if.slave bus
);
    localparam int CW = $clog2(PACK + 1);
    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {IDLE, FILL, FULL} state_t;

    state_t                          state, state_next;
    logic [CW-1:0]                   cnt, cnt_next, cnt_eff;
    logic                            inflight;
    logic                            run;
    logic [TW-1:0]                   timer, timer_next;
    logic                            flush_pend, flush_pend_next;
    logic [PACK-1:0][DATA_WIDTH-1:0] acc, acc_next, word;
    logic [PACK-1:0]                 word_keep;

    logic [DATA_WIDTH*PACK-1:0]      data_q;
    logic [PACK-1:0]                 keep_q;
    logic                            valid_q;

    logic pop, capture, out_free, timeout_hit, flush_ev, flush_req, xfer;

    // A byte popped last cycle is on dout now.
    assign capture     = inflight;
    assign out_free    = !valid_q || bus.m_ready;
    assign timeout_hit = (TIMEOUT != 0) && (timer == TW'(TIMEOUT));
    assign flush_ev    = (bus.flush || timeout_hit) && (cnt != '0);
    assign flush_req   = flush_ev || flush_pend;
    assign cnt_eff     = cnt + CW'(capture);

    // A flush that coincides with a capture folds the landing byte into the word.
    assign xfer = out_free && ((state == FULL) || (flush_req && (cnt_eff != '0)));

    // Pop only when the accumulator has room for every byte already requested.
    assign pop = run && !bus.empty
              && (({1'b0, cnt} + (CW+1)'(inflight)) < (CW+1)'(PACK))
              && !((state == FULL) && valid_q && !bus.m_ready);

    assign bus.r_en    = pop;
    assign bus.m_data  = data_q;
    assign bus.m_keep  = keep_q;
    assign bus.m_valid = valid_q;

    // Accumulator contents as they would stand after this cycle's capture.
    always_comb begin
        word      = acc;
        word_keep = '0;
        for (int unsigned i = 0; i < PACK; i++) begin
            if (capture && (CW'(i) == cnt)) begin
                word[i] = bus.dout;
            end
            word_keep[i] = (CW'(i) < cnt_eff);
        end
    end

    // Next-state: lane count, accumulator, idle timer, pending flush and FSM state.
    always_comb begin
        state_next      = state;
        cnt_next        = cnt;
        acc_next        = acc;
        timer_next      = timer;
        flush_pend_next = flush_pend;

        if (xfer) begin
            cnt_next        = '0;
            acc_next        = '0;
            timer_next      = '0;
            flush_pend_next = 1'b0;
        end else begin
            if (capture) begin
                acc_next   = word;
                cnt_next   = cnt_eff;
                timer_next = '0;
            end else if ((cnt != '0) && (TIMEOUT != 0) && !timeout_hit) begin
                timer_next = timer + TW'(1);
            end
            if (flush_ev) begin
                flush_pend_next = 1'b1;
            end
        end

        case (state)
            IDLE:    if (cnt_next != '0) state_next = FILL;
            FILL:    begin
                         if (xfer) state_next = IDLE;
                         else if (cnt_next == CW'(PACK)) state_next = FULL;
                     end
            FULL:    if (xfer) state_next = (cnt_next != '0) ? FILL : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Packer state registers; an in-flight byte is dropped by reset.
    always_ff @(posedge rclk or negedge rrst) begin
        if (!rrst) begin
            state      <= IDLE;
            cnt        <= '0;
            inflight   <= 1'b0;
            run        <= 1'b0;
            timer      <= '0;
            flush_pend <= 1'b0;
            acc        <= '0;
        end else begin
            state      <= state_next;
            cnt        <= cnt_next;
            inflight   <= pop;
            run        <= 1'b1;
            timer      <= timer_next;
            flush_pend <= flush_pend_next;
            acc        <= acc_next;
        end
    end

    // Output register: loads on transfer, holds while stalled, clears valid on accept.
    always_ff @(posedge rclk or negedge rrst) begin
        if (!rrst) begin
            data_q  <= '0;
            keep_q  <= '0;
            valid_q <= 1'b0;
        end else if (xfer) begin
            data_q  <= word;
            keep_q  <= word_keep;
            valid_q <= 1'b1;
        end else if (bus.m_ready) begin
            valid_q <= 1'b0;
        end
    end
endmodule

// File: tb/tb_fifo_rd_packer.sv
// Bench for fifo_rd_packer: a queue-based FIFO model feeds the packer, a
// monitor logs accepted words, and each task checks its scenario against
// the byte pop order.
module tb_fifo_rd_packer;
    logic rclk;
    logic rrst;

    fifo_rd_packer_if #(.DATA_WIDTH(8), .PACK(4)) bus ();

    fifo_rd_packer #(.DATA_WIDTH(8), .PACK(4), .TIMEOUT(16)) dut (
        .rclk (rclk),
        .rrst (rrst),
        .bus  (bus)
    );

    int tests_run = 0;
    int failed    = 0;

    logic [7:0]  fifo_q[$];
    logic [7:0]  popped_q[$];
    logic [31:0] out_data[$];
    logic [3:0]  out_keep[$];
    int          out_cyc[$];
    int          pop_total     = 0;
    int          cyc           = 0;
    int          ren_cnt       = 0;
    int          ren_empty_err = 0;
    int          stab_err      = 0;

    initial rclk = 1'b0;
    always #5 rclk = ~rclk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // FIFO model: pops on r_en at the edge, presents the byte shortly after.
    initial begin
        logic [7:0] nxt;
        logic       have;
        bus.empty = 1'b1;
        bus.dout  = '0;
        forever begin
            @(posedge rclk);
            have = 1'b0;
            if (bus.r_en) begin
                if (fifo_q.size() == 0) begin
                    ren_empty_err++;
                end else begin
                    nxt = fifo_q.pop_front();
                    popped_q.push_back(nxt);
                    pop_total++;
                    have = 1'b1;
                end
            end
            #2;
            bus.dout  = have ? nxt : 8'($urandom);
            bus.empty = (fifo_q.size() == 0);
        end
    end

    // Monitor: logs accepted words, stall stability and r_en-while-empty.
    initial begin
        logic        hold_prev;
        logic [31:0] prev_data;
        logic [3:0]  prev_keep;
        hold_prev = 1'b0;
        forever begin
            @(negedge rclk);
            cyc++;
            if (bus.r_en) ren_cnt++;
            if (bus.r_en && bus.empty) ren_empty_err++;
            if (hold_prev && rrst &&
                (!bus.m_valid || bus.m_data !== prev_data || bus.m_keep !== prev_keep))
                stab_err++;
            hold_prev = rrst && bus.m_valid && !bus.m_ready;
            prev_data = bus.m_data;
            prev_keep = bus.m_keep;
            if (rrst && bus.m_valid && bus.m_ready) begin
                out_data.push_back(bus.m_data);
                out_keep.push_back(bus.m_keep);
                out_cyc.push_back(cyc);
            end
        end
    end

    task automatic clear_logs();
        popped_q.delete();
        out_data.delete();
        out_keep.delete();
        out_cyc.delete();
    endtask

    task automatic test_reset();
        bus.m_ready = 1'b1;
        bus.flush   = 1'b0;
        rrst        = 1'b0;
        fifo_q.push_back(8'h11);
        fifo_q.push_back(8'h22);
        fifo_q.push_back(8'h33);
        fifo_q.push_back(8'h44);
        repeat (3) @(posedge rclk);
        @(negedge rclk);
        tests_run++;
        if (bus.r_en !== 1'b0) begin failed++; $display("FAIL reset_r_en: got %b want 0", bus.r_en); end
        tests_run++;
        if (bus.m_valid !== 1'b0) begin failed++; $display("FAIL reset_m_valid: got %b want 0", bus.m_valid); end
        tests_run++;
        if (bus.m_data !== 32'h0) begin failed++; $display("FAIL reset_m_data: got %h want 0", bus.m_data); end
        tests_run++;
        if (bus.m_keep !== 4'h0) begin failed++; $display("FAIL reset_m_keep: got %h want 0", bus.m_keep); end
        @(posedge rclk); #1 rrst = 1'b1;
        @(negedge rclk);
        tests_run++;
        if (bus.r_en !== 1'b0) begin failed++; $display("FAIL release_r_en_early: got %b want 0", bus.r_en); end
        @(posedge rclk); #3;
        tests_run++;
        if (bus.r_en !== 1'b1) begin failed++; $display("FAIL release_r_en_edge: got %b want 1", bus.r_en); end
    endtask

    task automatic test_single_word();
        for (int c = 0; c < 60 && out_data.size() < 1; c++) @(posedge rclk);
        tests_run++;
        if (out_data.size() < 1) begin
            failed++; $display("FAIL single_word_wait: got %0d words want 1", out_data.size());
        end else begin
            tests_run++;
            if (out_data[0] !== 32'h44332211) begin failed++; $display("FAIL single_word_data: got %h want 44332211", out_data[0]); end
            tests_run++;
            if (out_keep[0] !== 4'hF) begin failed++; $display("FAIL single_word_keep: got %h want f", out_keep[0]); end
        end
        repeat (4) @(posedge rclk);
        clear_logs();
    endtask

    task automatic test_stall();
        @(posedge rclk); #1;
        bus.m_ready = 1'b0;
        for (int i = 1; i <= 10; i++) fifo_q.push_back(8'(i));
        repeat (30) @(posedge rclk);
        @(negedge rclk);
        tests_run++;
        if (out_data.size() != 0) begin failed++; $display("FAIL stall_no_accept: got %0d words want 0", out_data.size()); end
        tests_run++;
        if (bus.m_valid !== 1'b1) begin failed++; $display("FAIL stall_valid: got %b want 1", bus.m_valid); end
        tests_run++;
        if (bus.m_data !== 32'h04030201) begin failed++; $display("FAIL stall_data: got %h want 04030201", bus.m_data); end
        tests_run++;
        if (fifo_q.size() != 2) begin failed++; $display("FAIL stall_pop_count: left %0d bytes want 2", fifo_q.size()); end
        @(posedge rclk); #1 bus.m_ready = 1'b1;
        for (int c = 0; c < 80 && out_data.size() < 3; c++) @(posedge rclk);
        tests_run++;
        if (out_data.size() < 3) begin
            failed++; $display("FAIL stall_wait: got %0d words want 3", out_data.size());
        end else begin
            tests_run++;
            if (out_data[0] !== 32'h04030201) begin failed++; $display("FAIL stall_word0: got %h want 04030201", out_data[0]); end
            tests_run++;
            if (out_data[1] !== 32'h08070605) begin failed++; $display("FAIL stall_word1: got %h want 08070605", out_data[1]); end
            tests_run++;
            if (out_cyc[1] - out_cyc[0] != 1) begin failed++; $display("FAIL stall_no_bubble: gap %0d want 1", out_cyc[1] - out_cyc[0]); end
            tests_run++;
            if (out_data[2] !== 32'h00000A09 || out_keep[2] !== 4'h3) begin
                failed++; $display("FAIL stall_tail: got %h/%h want 00000a09/3", out_data[2], out_keep[2]);
            end
        end
        tests_run++;
        if (stab_err != 0) begin failed++; $display("FAIL stall_stable: got %0d changes want 0", stab_err); end
        clear_logs();
    endtask

    task automatic test_timeout();
        int t0;
        @(posedge rclk); #1;
        t0 = cyc;
        fifo_q.push_back(8'hAA);
        fifo_q.push_back(8'hBB);
        for (int c = 0; c < 60 && out_data.size() < 1; c++) @(posedge rclk);
        tests_run++;
        if (out_data.size() < 1) begin
            failed++; $display("FAIL timeout_wait: got %0d words want 1", out_data.size());
        end else begin
            tests_run++;
            if (out_data[0] !== 32'h0000BBAA || out_keep[0] !== 4'h3) begin
                failed++; $display("FAIL timeout_word: got %h/%h want 0000bbaa/3", out_data[0], out_keep[0]);
            end
            tests_run++;
            if (out_cyc[0] - t0 < 16 || out_cyc[0] - t0 > 30) begin
                failed++; $display("FAIL timeout_latency: got %0d cycles want 16..30", out_cyc[0] - t0);
            end
        end
        clear_logs();
        @(posedge rclk); #1;
        t0 = cyc;
        fifo_q.push_back(8'hAA);
        fifo_q.push_back(8'hBB);
        repeat (6) @(posedge rclk);
        #1 bus.flush = 1'b1;
        @(posedge rclk); #1 bus.flush = 1'b0;
        for (int c = 0; c < 60 && out_data.size() < 1; c++) @(posedge rclk);
        tests_run++;
        if (out_data.size() < 1) begin
            failed++; $display("FAIL flush_wait: got %0d words want 1", out_data.size());
        end else begin
            tests_run++;
            if (out_data[0] !== 32'h0000BBAA || out_keep[0] !== 4'h3) begin
                failed++; $display("FAIL flush_word: got %h/%h want 0000bbaa/3", out_data[0], out_keep[0]);
            end
            tests_run++;
            if (out_cyc[0] - t0 >= 16) begin failed++; $display("FAIL flush_latency: got %0d cycles want <16", out_cyc[0] - t0); end
        end
        clear_logs();
    endtask

    task automatic test_empty();
        int base;
        repeat (2) @(posedge rclk);
        base = ren_cnt;
        for (int c = 0; c < 40; c++) begin
            @(posedge rclk); #1;
            bus.flush = (c % 8 == 3);
        end
        @(posedge rclk); #1 bus.flush = 1'b0;
        repeat (3) @(posedge rclk);
        @(negedge rclk);
        tests_run++;
        if (ren_cnt != base) begin failed++; $display("FAIL empty_r_en: got %0d pops want 0", ren_cnt - base); end
        tests_run++;
        if (out_data.size() != 0) begin failed++; $display("FAIL empty_flush_word: got %0d words want 0", out_data.size()); end
        clear_logs();
    endtask

    task automatic test_reset_mid();
        int base;
        logic [7:0] b[7];
        for (int i = 0; i < 7; i++) b[i] = 8'($urandom);
        @(posedge rclk); #1;
        base = pop_total;
        for (int i = 0; i < 5; i++) fifo_q.push_back(b[i]);
        for (int c = 0; c < 20 && pop_total < base + 3; c++) begin
            @(posedge rclk); #3;
        end
        tests_run++;
        if (pop_total < base + 3) begin
            failed++; $display("FAIL midreset_pops: got %0d pops want 3", pop_total - base);
        end
        rrst = 1'b0;
        #1;
        tests_run++;
        if (bus.r_en !== 1'b0 || bus.m_valid !== 1'b0 || bus.m_data !== 32'h0 || bus.m_keep !== 4'h0) begin
            failed++; $display("FAIL midreset_outputs: got r_en=%b valid=%b data=%h keep=%h want all 0",
                               bus.r_en, bus.m_valid, bus.m_data, bus.m_keep);
        end
        @(posedge rclk); #1;
        clear_logs();
        rrst = 1'b1;
        fifo_q.push_back(b[5]);
        fifo_q.push_back(b[6]);
        for (int c = 0; c < 60 && out_data.size() < 1; c++) @(posedge rclk);
        tests_run++;
        if (out_data.size() < 1) begin
            failed++; $display("FAIL midreset_wait: got %0d words want 1", out_data.size());
        end else begin
            tests_run++;
            if (out_data[0] !== {b[6], b[5], b[4], b[3]} || out_keep[0] !== 4'hF) begin
                failed++; $display("FAIL midreset_word: got %h/%h want %h/f", out_data[0], out_keep[0],
                                   {b[6], b[5], b[4], b[3]});
            end
        end
        repeat (4) @(posedge rclk);
        clear_logs();
    endtask

    task automatic test_random();
        int         n;
        logic [3:0] exp_k;
        logic [7:0] exp_b;
        for (int c = 0; c < 1500; c++) begin
            @(posedge rclk); #1;
            if ($urandom_range(0, 2) == 0 && fifo_q.size() < 8) fifo_q.push_back(8'($urandom));
            bus.m_ready = ($urandom_range(0, 2) != 0);
            bus.flush   = ($urandom_range(0, 19) == 0);
        end
        @(posedge rclk); #1;
        bus.flush   = 1'b0;
        bus.m_ready = 1'b1;
        for (int c = 0; c < 200 && fifo_q.size() != 0; c++) @(posedge rclk);
        repeat (60) @(posedge rclk);
        tests_run++;
        if (out_data.size() < 20) begin failed++; $display("FAIL random_words: got %0d words want >=20", out_data.size()); end
        for (int w = 0; w < out_data.size(); w++) begin
            n = $countones(out_keep[w]);
            exp_k = 4'((1 << n) - 1);
            tests_run++;
            if (n == 0 || out_keep[w] !== exp_k) begin
                failed++; $display("FAIL random_keep[%0d]: got %h want nonzero contiguous %h", w, out_keep[w], exp_k);
            end
            for (int i = 0; i < 4; i++) begin
                if (i < n) exp_b = (popped_q.size() > 0) ? popped_q.pop_front() : 8'hxx;
                else       exp_b = 8'h00;
                tests_run++;
                if (out_data[w][i*8 +: 8] !== exp_b) begin
                    failed++; $display("FAIL random_lane[%0d][%0d]: got %h want %h", w, i, out_data[w][i*8 +: 8], exp_b);
                end
            end
        end
        tests_run++;
        if (popped_q.size() != 0) begin failed++; $display("FAIL random_lost: %0d popped bytes never emitted", popped_q.size()); end
        tests_run++;
        if (stab_err != 0) begin failed++; $display("FAIL random_stable: got %0d changes want 0", stab_err); end
        tests_run++;
        if (ren_empty_err != 0) begin failed++; $display("FAIL r_en_while_empty: got %0d want 0", ren_empty_err); end
        clear_logs();
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_stall();
        test_timeout();
        test_empty();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end
endmodule
